// File: rtl/riscv_if_pkg.sv
// Shared fetch-side types and defaults: widths, reset PC, the idle NOP
// encoding and the {pc, insn} queue entry.
package riscv_if_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // addi x0, x0, 0 -- presented on inst whenever the head is not valid
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch bus bundle: ROM read port plus the valid/ready decode handshake.
// master = fetch unit, slave = ROM/decode side.
interface fetch_queue_unit_if
  import riscv_if_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ROM_AW = 6
);
  logic [ROM_AW-1:0] rom_addr;
  logic [XLEN-1:0]   rom_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   inst_pc;

  modport master (
    output rom_addr, inst_valid, inst, inst_pc,
    input  rom_data, inst_ready
  );

  modport slave (
    input  rom_addr, inst_valid, inst, inst_pc,
    output rom_data, inst_ready
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: synchronous power-of-2 FIFO with a synchronous clear.
// The caller guarantees no push into a full FIFO without a same-cycle pop.
module fetch_fifo
  import riscv_if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output logic [CW-1:0] count,
  output T              head
);
  localparam int PW = $clog2(DEPTH);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q;

  // Pointer/count bookkeeping; clear wins over any push/pop
  always_ff @(posedge clk) begin
    if (clear) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage; contents need no reset because the count masks stale words
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wp_q] <= din;
  end

  assign head  = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch PC, ROM read and a decoupling queue to decode.
// Redirect flushes the queue and reloads the PC. Optional same-cycle
// bypass of an empty queue is enabled with `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue_unit
  import riscv_if_pkg::*;
#(
  parameter int          XLEN        = XLEN_DEFAULT,
  parameter int          ROM_DEPTH   = 64,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  localparam int         ROM_AW      = $clog2(ROM_DEPTH),
  localparam int         OW          = $clog2(QUEUE_DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic [OW-1:0]     occupancy,
  fetch_queue_unit_if.master bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   count;
  entry_t          fifo_head, head, fetched;
  logic            full, enq, deq, push, pop, byp;

  assign fetched = '{pc: pc_q, insn: bus.rom_data};
  assign full    = (count == OW'(QUEUE_DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: hand the word being fetched straight to decode
  assign byp = (count == '0) & fetch_en & ~redirect_valid;
`else
  assign byp = 1'b0;
`endif

  assign head           = byp ? fetched : fifo_head;
  assign bus.inst_valid = byp | ((count != '0) & ~redirect_valid);
  assign deq            = bus.inst_valid & bus.inst_ready;
  // A same-cycle dequeue frees a slot, so a full queue can still accept
  assign enq            = fetch_en & ~redirect_valid & (~full | deq);
  // A bypassed word that is consumed never touches the queue
  assign push           = enq & ~(byp & bus.inst_ready);
  assign pop            = deq & ~byp;

  // Next PC: redirect beats sequential advance; stall holds
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (enq)        pc_d = pc_q + XLEN'(4);
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_fifo #(.DEPTH(QUEUE_DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .clear (reset | redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (fetched),
    .count (count),
    .head  (fifo_head)
  );

  assign bus.rom_addr = pc_q[ROM_AW+1:2];
  assign bus.inst     = bus.inst_valid ? head.insn : XLEN'(NOP_INSN);
  assign bus.inst_pc  = bus.inst_valid ? head.pc   : '0;
  assign flush        = redirect_valid;
  assign occupancy    = count;

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch stage with a decoupling queue between the instruction ROM and decode. The block owns the fetch PC and reads the ROM one word per cycle. Fetched {pc, instruction} pairs are buffered in a FIFO and presented to decode over a valid/ready handshake. A redirect (branch or jump) flushes the queue and restarts fetch at the target address.

## Interface
Parameters:
- XLEN, 32, data and address width.
- ROM_DEPTH, 64, ROM size in words; must be a power of 2. ROM_AW = $clog2(ROM_DEPTH).
- QUEUE_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk, input, 1, single clock for the whole block.
- reset, input, 1, synchronous, active-high.
- fetch_en, input, 1, fetch enable; when low, the PC holds and nothing is enqueued.
- redirect_valid, input, 1, flush the queue and load a new PC.
- redirect_pc, input, XLEN, redirect target; bits [1:0] are ignored and treated as 0.
- rom_addr, output, ROM_AW, word index into the ROM; equals pc[ROM_AW+1:2].
- rom_data, input, XLEN, combinational ROM read data for rom_addr.
- inst_valid, output, 1, the head entry is valid.
- inst_ready, input, 1, decode accepts the head entry.
- inst, output, XLEN, instruction at the head entry.
- inst_pc, output, XLEN, PC of the head entry.
- flush, output, 1, equals redirect_valid; used to squash downstream pipeline registers.
- occupancy, output, $clog2(QUEUE_DEPTH+1), number of valid entries in the queue.

## Operation
- Enqueue condition, per cycle: enq = fetch_en & ~redirect_valid & (count < QUEUE_DEPTH | deq).
- On enq, the entry {pc, rom_data} is written to the queue and pc advances by 4. Otherwise pc holds.
- Dequeue condition: deq = inst_valid & inst_ready.
- inst_valid = (count != 0) & ~redirect_valid. A handshake can never complete in a redirect cycle.
- Redirect has priority over every other event:
  - the next pc becomes {redirect_pc[XLEN-1:2], 2'b00};
  - the queue is emptied (count = 0, pointers = 0);
  - any enqueue or dequeue in that cycle is discarded.
- Simultaneous enqueue and dequeue is legal at any fill level, including full. Count is unchanged.
- PC arithmetic is modulo 2^XLEN. ROM addressing wraps modulo ROM_DEPTH because rom_addr takes only the low PC bits.
- A full queue with no dequeue stalls fetch: pc holds and rom_addr is stable.
- fetch_en low does not block dequeue; the queue drains normally.

## Timing
- Reset values: pc = RESET_PC, count = 0, queue pointers = 0. Outputs: inst_valid = 0, occupancy = 0, flush = 0 (follows redirect_valid), inst = 0, inst_pc = 0.
- Reset asserted in the middle of operation discards all entries on the next edge.
- Fetch latency, without bypass: a word fetched in cycle N is at the head with inst_valid = 1 in cycle N+1, provided the queue was empty.
- Redirect asserted in cycle N:
  - cycle N+1: target is fetched;
  - cycle N+2: target is visible at the head.
- Throughput: one instruction per cycle when inst_ready is held high.
- rom_addr is driven combinationally from the pc register. rom_data must settle within the same cycle.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - when count == 0 and fetch_en & ~redirect_valid, the head presents {pc, rom_data} directly with inst_valid = 1;
  - if inst_ready is high that cycle, the word is consumed and not enqueued;
  - result: zero-cycle fetch latency, and redirect-to-target latency drops to 1 cycle.
- FETCH_QUEUE_BYPASS_EN undefined: the registered-only path with the latencies listed under Timing.

## Structure
- Shared package riscv_if_pkg contains:
  - XLEN default;
  - RESET_PC default;
  - NOP_INSN = 32'h0000_0013, driven on inst when inst_valid is low (replaces the reset value 0 only if the package is in use);
  - fetch_entry_t struct {pc, insn}.
- One sub-module: fetch_fifo, a synchronous FIFO with parameter DEPTH and ports clear, push, pop, count, head. The PC, enqueue logic and bypass stay in fetch_queue_unit.

## Test plan
- Reset, then fetch_en = 1, inst_ready = 1, no bypass:
  - the cycle after reset, inst_valid = 1, inst_pc = 0x0, inst = ROM[0];
  - then inst_pc advances 0x4, 0x8, … one per cycle.
- inst_ready = 0 for 10 cycles, QUEUE_DEPTH = 4:
  - occupancy saturates at 4 and rom_addr freezes at 4;
  - after inst_ready rises, inst_pc sequence 0x0…0xC comes out with no gap or duplicate.
- With the queue at 3 entries, assert redirect_valid with redirect_pc = 0x23:
  - that cycle: inst_valid = 0 and flush = 1;
  - next cycle: occupancy = 0 and rom_addr = 8;
  - cycle after: inst_pc = 0x20.
- ROM_DEPTH = 64, run pc past 0xFC: rom_addr wraps to 0 while inst_pc reads 0x100.
- fetch_en = 0 with 2 entries queued and inst_ready = 1: both entries drain, then inst_valid = 0 and pc is unchanged.
- With FETCH_QUEUE_BYPASS_EN and a redirect to 0x40: inst_pc = 0x40 with inst_valid = 1 in the very next cycle, and occupancy stays 0.
